getir_birimi: RTL

- Fetch-stage front end that owns the program counter (PS) and issues instruction-memory requests.
- Queues fetched instructions for decode.
- Hands conditional-branch PCs and B-type immediates to the gshare predictor, and consumes the predicted next PS one cycle later.
- Accepts execute-stage redirects, flushing the queue and any in-flight fetch.

---
 rtl/getir_birimi.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/getir_birimi.sv
// Fetch stage front end: owns the program counter, keeps at most one instruction-memory
// request in flight, queues fetched words for decode and asks the gshare predictor about branches.
module getir_birimi #(
    parameter logic [31:0] BASLANGIC_PS     = 32'h0000_0000,
    parameter int unsigned KUYRUK_DERINLIGI = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        bellek_istek_o,
    output logic [31:0] bellek_adres_o,
    input  logic        bellek_hazir_i,
    input  logic        bellek_yanit_gecerli_i,
    input  logic [31:0] bellek_buyruk_i,
    output logic        tahmin_ps_gecerli_o,
    output logic [31:0] tahmin_ps_o,
    output logic [31:0] ongoru_genisletilmis_anlik_o,
    input  logic        ongorulen_ps_gecerli_i,
    input  logic [31:0] ongorulen_ps_i,
    input  logic        yurut_yonlendir_i,
    input  logic [31:0] yurut_ps_i,
    output logic        cozme_gecerli_o,
    output logic [31:0] cozme_buyruk_o,
    output logic [31:0] cozme_ps_o,
    input  logic        cozme_hazir_i
);
    localparam int unsigned PW       = $clog2(KUYRUK_DERINLIGI);
    localparam logic [PW:0] DERINLIK = KUYRUK_DERINLIGI[PW:0];
    localparam logic [6:0]  OP_DAL   = 7'b1100011;
    localparam logic [6:0]  OP_JAL   = 7'b1101111;

    typedef enum logic [2:0] {BOSTA, ISTEK, BEKLE, TAHMIN, IPTAL} durum_t;

    durum_t        durum_q;
    logic [31:0]   ps_q, ps_d;
    logic [31:0]   adres_q;
    logic          istek_q;
    logic          iptal_q;
    logic          tahmin_gecerli_q;
    logic [31:0]   tahmin_ps_q;
    logic [31:0]   anlik_q;
    logic [31:0]   kuyruk_buyruk_q [KUYRUK_DERINLIGI];
    logic [31:0]   kuyruk_ps_q     [KUYRUK_DERINLIGI];
    logic [PW-1:0] oku_q, yaz_q;
    logic [PW:0]   sayac_q;

    logic          bekle_yanit, it, cikar, bos_degil, yer_var;
    logic [6:0]    opkod;
    logic [31:0]   b_anlik, j_anlik;

    always_comb begin
        opkod       = bellek_buyruk_i[6:0];
        b_anlik     = {{20{bellek_buyruk_i[31]}}, bellek_buyruk_i[7], bellek_buyruk_i[30:25],
                       bellek_buyruk_i[11:8], 1'b0};
        j_anlik     = {{12{bellek_buyruk_i[31]}}, bellek_buyruk_i[19:12], bellek_buyruk_i[20],
                       bellek_buyruk_i[30:21], 1'b0};
        bos_degil   = (sayac_q != '0);
        bekle_yanit = (durum_q == BEKLE) && bellek_yanit_gecerli_i;
        it          = bekle_yanit && !yurut_yonlendir_i;
        cikar       = bos_degil && cozme_hazir_i && !yurut_yonlendir_i;
        // one slot stays reserved for the fetch about to be issued
        yer_var     = (sayac_q - {{PW{1'b0}}, cikar}) < DERINLIK;
    end

    always_comb begin
        ps_d = ps_q;
        if (yurut_yonlendir_i) begin
            ps_d = yurut_ps_i & ~32'd3;
        end else if (bekle_yanit) begin
            if (opkod == OP_JAL) begin
                ps_d = (ps_q + j_anlik) & ~32'd3;
            end else if (opkod != OP_DAL) begin
                ps_d = ps_q + 32'd4;
            end
        end else if ((durum_q == TAHMIN) && ongorulen_ps_gecerli_i) begin
            ps_d = ongorulen_ps_i & ~32'd3;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i && it) begin
            kuyruk_buyruk_q[yaz_q] <= bellek_buyruk_i;
            kuyruk_ps_q[yaz_q]     <= ps_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            durum_q          <= BOSTA;
            ps_q             <= BASLANGIC_PS;
            adres_q          <= BASLANGIC_PS;
            istek_q          <= 1'b0;
            iptal_q          <= 1'b0;
            tahmin_gecerli_q <= 1'b0;
            tahmin_ps_q      <= '0;
            anlik_q          <= '0;
            oku_q            <= '0;
            yaz_q            <= '0;
            sayac_q          <= '0;
        end else begin
            ps_q             <= ps_d;
            tahmin_gecerli_q <= 1'b0;

            if (yurut_yonlendir_i) begin
                oku_q   <= '0;
                yaz_q   <= '0;
                sayac_q <= '0;
            end else begin
                if (it)   yaz_q <= yaz_q + 1'b1;
                if (cikar) oku_q <= oku_q + 1'b1;
                if (it && !cikar)      sayac_q <= sayac_q + 1'b1;
                else if (cikar && !it) sayac_q <= sayac_q - 1'b1;
            end

            case (durum_q)
                BOSTA: begin
                    if (!yurut_yonlendir_i && yer_var) begin
                        durum_q <= ISTEK;
                        istek_q <= 1'b1;
                        adres_q <= ps_q;
                    end
                end
                ISTEK: begin
                    // a redirect seen while waiting keeps the address; the reply is dropped in IPTAL
                    if (bellek_hazir_i) begin
                        istek_q <= 1'b0;
                        iptal_q <= 1'b0;
                        durum_q <= (iptal_q || yurut_yonlendir_i) ? IPTAL : BEKLE;
                    end else if (yurut_yonlendir_i) begin
                        iptal_q <= 1'b1;
                    end
                end
                BEKLE: begin
                    if (yurut_yonlendir_i) begin
                        durum_q <= bellek_yanit_gecerli_i ? BOSTA : IPTAL;
                    end else if (bellek_yanit_gecerli_i) begin
                        if (opkod == OP_DAL) begin
                            tahmin_gecerli_q <= 1'b1;
                            tahmin_ps_q      <= ps_q;
                            anlik_q          <= b_anlik;
                            durum_q          <= TAHMIN;
                        end else begin
                            durum_q <= BOSTA;
                        end
                    end
                end
                TAHMIN: begin
                    if (yurut_yonlendir_i || ongorulen_ps_gecerli_i) durum_q <= BOSTA;
                end
                IPTAL: begin
                    if (bellek_yanit_gecerli_i) durum_q <= BOSTA;
                end
                default: durum_q <= BOSTA;
            endcase
        end
    end

    assign bellek_istek_o               = istek_q;
    assign bellek_adres_o               = adres_q;
    assign tahmin_ps_gecerli_o          = tahmin_gecerli_q;
    assign tahmin_ps_o                  = tahmin_ps_q;
    assign ongoru_genisletilmis_anlik_o = anlik_q;
    assign cozme_gecerli_o              = bos_degil;
    assign cozme_buyruk_o               = bos_degil ? kuyruk_buyruk_q[oku_q] : '0;
    assign cozme_ps_o                   = bos_degil ? kuyruk_ps_q[oku_q] : '0;

endmodule
